// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the fetched word for decode and slices out the immediate fields.
module busca_instrucao #(
    parameter logic [31:0] PC_INICIAL    = 32'h0000_0000,
    parameter logic [31:0] INCREMENTO    = 32'd4,
    parameter int          LIMITE_ESPERA = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] endereco_mem,
    output logic        req_mem,
    input  logic        ack_mem,
    input  logic [31:0] dado_mem,
    input  logic        avancar,
    input  logic        desvio,
    input  logic [31:0] endereco_desvio,
    output logic [31:0] instrucao,
    output logic [31:0] pc_instrucao,
    output logic        valido,
    output logic [4:0]  opcode,
    output logic [1:0]  selecao,
    output logic [19:0] entrada1,
    output logic [13:0] entrada2,
    output logic [14:0] entrada3,
    output logic        erro_busca
);

    localparam int CW = (LIMITE_ESPERA > 2) ? $clog2(LIMITE_ESPERA) : 1;
    localparam logic [CW-1:0] CONT_MAX = CW'(LIMITE_ESPERA - 1);

    typedef enum logic [1:0] {
        BUSCA  = 2'd0,
        ESPERA = 2'd1,
        PRONTO = 2'd2
    } estado_t;

    estado_t       estado;
    logic [31:0]   pc;
    logic [CW-1:0] contador;

    // Redirect beats everything, including an ack landing in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado       <= BUSCA;
            pc           <= PC_INICIAL;
            instrucao    <= '0;
            pc_instrucao <= '0;
            valido       <= 1'b0;
            erro_busca   <= 1'b0;
            contador     <= '0;
        end else if (desvio) begin
            pc       <= endereco_desvio;
            valido   <= 1'b0;
            estado   <= BUSCA;
            contador <= '0;
        end else begin
            case (estado)
                BUSCA: begin
                    contador <= '0;
                    estado   <= ESPERA;
                end
                ESPERA: begin
                    if (ack_mem) begin
                        instrucao    <= dado_mem;
                        pc_instrucao <= pc;
                        pc           <= pc + INCREMENTO;
                        valido       <= 1'b1;
                        estado       <= PRONTO;
                    end else if (contador == CONT_MAX) begin
                        erro_busca <= 1'b1;
                        estado     <= BUSCA;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end
                PRONTO: begin
                    if (avancar) begin
                        valido <= 1'b0;
                        estado <= BUSCA;
                    end
                end
                default: estado <= BUSCA;
            endcase
        end
    end

    assign req_mem      = (estado == ESPERA);
    assign endereco_mem = pc;
    assign opcode       = instrucao[31:27];
    assign entrada1     = instrucao[19:0];
    assign entrada2     = instrucao[13:0];
    assign entrada3     = instrucao[14:0];

    always_comb begin
        selecao = 2'b11;
        case (opcode[4:3])
            2'b00:   selecao = 2'b11;
            2'b01:   selecao = 2'b10;
            2'b10:   selecao = 2'b01;
            default: selecao = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao: stimulus queues expected words,
// a negedge monitor checks each newly presented instruction.
module tb_busca_instrucao;

    logic        clock;
    logic        reset;
    logic        ack_mem;
    logic [31:0] dado_mem;
    logic        avancar;
    logic        desvio;
    logic [31:0] endereco_desvio;

    logic [31:0] endereco_mem, instrucao, pc_instrucao;
    logic        req_mem, valido, erro_busca;
    logic [4:0]  opcode;
    logic [1:0]  selecao;
    logic [19:0] entrada1;
    logic [13:0] entrada2;
    logic [14:0] entrada3;

    logic [31:0] b_endereco_mem, b_instrucao, b_pc_instrucao;
    logic        b_req_mem, b_valido, b_erro_busca;
    logic [4:0]  b_opcode;
    logic [1:0]  b_selecao;
    logic [19:0] b_entrada1;
    logic [13:0] b_entrada2;
    logic [14:0] b_entrada3;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [1:0]  sel;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic valido_q = 1'b0;

    busca_instrucao #(.PC_INICIAL(32'h0000_0000), .INCREMENTO(32'd4), .LIMITE_ESPERA(4)) dut (
        .clock(clock), .reset(reset), .endereco_mem(endereco_mem), .req_mem(req_mem),
        .ack_mem(ack_mem), .dado_mem(dado_mem), .avancar(avancar), .desvio(desvio),
        .endereco_desvio(endereco_desvio), .instrucao(instrucao), .pc_instrucao(pc_instrucao),
        .valido(valido), .opcode(opcode), .selecao(selecao), .entrada1(entrada1),
        .entrada2(entrada2), .entrada3(entrada3), .erro_busca(erro_busca)
    );

    // Second instance starting near the top of the address space, same stimulus.
    busca_instrucao #(.PC_INICIAL(32'hFFFF_FFFC), .INCREMENTO(32'd4), .LIMITE_ESPERA(4)) dut_b (
        .clock(clock), .reset(reset), .endereco_mem(b_endereco_mem), .req_mem(b_req_mem),
        .ack_mem(ack_mem), .dado_mem(dado_mem), .avancar(avancar), .desvio(desvio),
        .endereco_desvio(endereco_desvio), .instrucao(b_instrucao), .pc_instrucao(b_pc_instrucao),
        .valido(b_valido), .opcode(b_opcode), .selecao(b_selecao), .entrada1(b_entrada1),
        .entrada2(b_entrada2), .entrada3(b_entrada3), .erro_busca(b_erro_busca)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait for a request, ack it with the given word and queue the expected view.
    task automatic applyStimulus(input logic [31:0] word, input logic [31:0] addr, input logic [1:0] sel);
        int n;
        n = 0;
        while (!req_mem && n < 20) begin
            tick();
            n++;
        end
        checkOutput("req_wait", {31'b0, req_mem}, 32'd1);
        checkOutput("fetch_addr", endereco_mem, addr);
        ack_mem  = 1'b1;
        dado_mem = word;
        sb.push_back('{word: word, pc: addr, sel: sel});
        tick();
        ack_mem  = 1'b0;
        dado_mem = '0;
        checkOutput("valido_after_ack", {31'b0, valido}, 32'd1);
    endtask

    task automatic advance_once();
        avancar = 1'b1;
        tick();
        avancar = 1'b0;
    endtask

    // Monitor: each rising valido must match the oldest queued expectation.
    always @(negedge clock) begin
        if (valido && !valido_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word: got 0x%08h expected none", instrucao);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_instrucao", instrucao, e.word);
                checkOutput("sb_pc_instrucao", pc_instrucao, e.pc);
                checkOutput("sb_opcode", {27'b0, opcode}, {27'b0, e.word[31:27]});
                checkOutput("sb_selecao", {30'b0, selecao}, {30'b0, e.sel});
                checkOutput("sb_entrada1", {12'b0, entrada1}, {12'b0, e.word[19:0]});
                checkOutput("sb_entrada2", {18'b0, entrada2}, {18'b0, e.word[13:0]});
                checkOutput("sb_entrada3", {17'b0, entrada3}, {17'b0, e.word[14:0]});
            end
        end
        valido_q = valido;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; ack_mem = 1'b0; dado_mem = '0; avancar = 1'b0;
        desvio = 1'b0; endereco_desvio = '0;
        tick(); tick();

        // Reset state
        checkOutput("rst_valido", {31'b0, valido}, 32'd0);
        checkOutput("rst_req", {31'b0, req_mem}, 32'd0);
        checkOutput("rst_addr", endereco_mem, 32'h0);
        checkOutput("rst_instrucao", instrucao, 32'h0);
        checkOutput("rst_pc_instrucao", pc_instrucao, 32'h0);
        checkOutput("rst_selecao", {30'b0, selecao}, 32'd3);
        checkOutput("rst_erro", {31'b0, erro_busca}, 32'd0);
        checkOutput("rst_b_addr", b_endereco_mem, 32'hFFFF_FFFC);

        // Single fetch right after release
        reset = 1'b1;
        tick();
        checkOutput("first_req", {31'b0, req_mem}, 32'd1);
        applyStimulus(32'h4800_1234, 32'h0, 2'b10);
        checkOutput("pc_after_fetch", endereco_mem, 32'h4);
        checkOutput("first_opcode", {27'b0, opcode}, 32'h09);
        checkOutput("first_entrada3", {17'b0, entrada3}, 32'h1234);

        // Wrap-around on the second instance
        checkOutput("wrap_pc_instrucao", b_pc_instrucao, 32'hFFFF_FFFC);
        checkOutput("wrap_next_addr", b_endereco_mem, 32'h0);

        // Stall in PRONTO
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_valido", {31'b0, valido}, 32'd1);
            checkOutput("stall_req", {31'b0, req_mem}, 32'd0);
            checkOutput("stall_instrucao", instrucao, 32'h4800_1234);
        end
        advance_once();
        checkOutput("adv_valido", {31'b0, valido}, 32'd0);
        checkOutput("adv_req_low", {31'b0, req_mem}, 32'd0);
        tick();
        checkOutput("adv_req_high", {31'b0, req_mem}, 32'd1);
        checkOutput("adv_addr", endereco_mem, 32'h4);

        // Jump then branch decode
        applyStimulus(32'hF80F_FFFF, 32'h4, 2'b00);
        checkOutput("jump_entrada1", {12'b0, entrada1}, 32'hF_FFFF);
        advance_once();
        applyStimulus(32'h8000_2001, 32'h8, 2'b01);
        checkOutput("branch_entrada2", {18'b0, entrada2}, 32'h2001);

        // Timeout and retry at the same address
        advance_once();
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_req_high", {31'b0, req_mem}, 32'd1);
            checkOutput("to_addr", endereco_mem, 32'hC);
            tick();
        end
        checkOutput("to_req_low", {31'b0, req_mem}, 32'd0);
        checkOutput("to_erro", {31'b0, erro_busca}, 32'd1);
        tick();
        checkOutput("to_retry_req", {31'b0, req_mem}, 32'd1);
        checkOutput("to_retry_addr", endereco_mem, 32'hC);

        // Redirect colliding with an ack
        ack_mem = 1'b1; dado_mem = 32'hDEAD_BEEF;
        desvio = 1'b1; endereco_desvio = 32'h100;
        tick();
        ack_mem = 1'b0; dado_mem = '0; desvio = 1'b0;
        checkOutput("col_valido", {31'b0, valido}, 32'd0);
        checkOutput("col_req", {31'b0, req_mem}, 32'd0);
        checkOutput("col_addr", endereco_mem, 32'h100);
        tick();
        checkOutput("col_req_next", {31'b0, req_mem}, 32'd1);
        checkOutput("col_erro_sticky", {31'b0, erro_busca}, 32'd1);
        applyStimulus(32'h0000_0007, 32'h100, 2'b11);

        // Redirect with avancar in PRONTO drops the held word
        avancar = 1'b1; desvio = 1'b1; endereco_desvio = 32'h200;
        tick();
        avancar = 1'b0; desvio = 1'b0;
        checkOutput("pr_desvio_valido", {31'b0, valido}, 32'd0);
        checkOutput("pr_desvio_addr", endereco_mem, 32'h200);
        applyStimulus(32'h5000_7FFF, 32'h200, 2'b10);

        // Reset clears the sticky error
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("rst2_erro", {31'b0, erro_busca}, 32'd0);
        checkOutput("rst2_addr", endereco_mem, 32'h0);
        tick(); tick();

        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch stage with instruction register, sitting directly upstream of the immediate sign-extension stage. It fetches 32-bit words from instruction memory over a request/acknowledge handshake and holds each word until the decode stage accepts it. It also slices out the three immediate fields (20/14/15 bit) and the 2-bit format select that the extension stage consumes. It owns the program counter and accepts branch/jump redirects.

## Interface
- PC_INICIAL, 32'h0000_0000, PC value loaded on reset
- INCREMENTO, 4, PC step after each accepted fetch
- LIMITE_ESPERA, 16, cycles in ESPERA without ack_mem before the request is retried (≥2)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- endereco_mem  out  32  fetch address (= pc)
- req_mem  out  1  memory request, high only in state ESPERA
- ack_mem  in  1  memory acknowledge; dado_mem is valid in the same cycle
- dado_mem  in  32  fetched instruction word
- avancar  in  1  downstream accepts the held instruction
- desvio  in  1  redirect request
- endereco_desvio  in  32  redirect target
- instrucao  out  32  instruction register
- pc_instrucao  out  32  address of instrucao
- valido  out  1  instrucao is valid and unconsumed
- opcode  out  5  instrucao[31:27]
- selecao  out  2  immediate format select for the extension stage
- entrada1  out  20  instrucao[19:0] (jump immediate)
- entrada2  out  14  instrucao[13:0] (branch immediate)
- entrada3  out  15  instrucao[14:0] (I-type immediate)
- erro_busca  out  1  sticky flag: at least one fetch timed out

## Operation
- States: BUSCA, ESPERA, PRONTO. All state, pc, instrucao, pc_instrucao, valido, erro_busca and the wait counter are registered. req_mem = (estado == ESPERA). endereco_mem = pc.
- BUSCA: one address-setup cycle; clear wait counter; go to ESPERA.
- ESPERA: if ack_mem, then instrucao <= dado_mem, pc_instrucao <= pc, pc <= pc + INCREMENTO (mod 2^32), valido <= 1, and go to PRONTO. Otherwise the counter increments. When it reaches LIMITE_ESPERA-1 without ack, erro_busca <= 1 and go to BUSCA with pc unchanged (retry).
- PRONTO: hold instrucao and valido stable. If avancar, valido <= 0 and go to BUSCA.
- desvio (any state) has top priority: pc <= endereco_desvio, valido <= 0, go to BUSCA. An ack_mem in the same cycle is discarded and pc does not increment. A pending request is withdrawn, and memory tolerates withdrawal.
- avancar while valido = 0 is ignored. avancar together with desvio: desvio wins, and the held instruction is dropped.
- selecao is decoded combinationally from opcode[4:3]:
  - 00: R-type, selecao = 2'b11
  - 01: I-type, selecao = 2'b10
  - 10: branch, selecao = 2'b01
  - 11: jump, selecao = 2'b00
- entrada1/2/3 are plain slices of instrucao, with no sign extension here.
- Reset (reset = 0 at a rising edge):
  - pc = PC_INICIAL, estado = BUSCA, valido = 0, instrucao = 0, pc_instrucao = 0, erro_busca = 0, counter = 0.
  - Hence req_mem = 0, opcode = 0, selecao = 2'b11, entrada1/2/3 = 0.
  - Reset mid-ESPERA drops req_mem the next cycle and ignores any ack in the reset cycle.
- erro_busca clears only on reset.

## Timing
- Fetch latency from BUSCA with ack in the first ESPERA cycle: BUSCA at T, req_mem/ack at T+1, valido = 1 at T+2.
- Minimum issue interval with avancar held high: 3 cycles per instruction (PRONTO, BUSCA, ESPERA).
- Each extra ack wait cycle adds 1. A timeout costs LIMITE_ESPERA cycles plus 1 BUSCA cycle per retry.
- desvio at cycle T: valido = 0 and pc = endereco_desvio at T+1, state BUSCA at T+1, req_mem at T+2.
- Outputs change only on rising clock edges. selecao/opcode/entradaN follow instrucao in the same cycle.

## Test plan
- Reset then single fetch:
  - Stimulus: release reset; ack_mem = 1 in the first ESPERA cycle with dado_mem = 32'h4800_1234.
  - Required: endereco_mem = 0; valido at the 3rd cycle after release; opcode = 5'b01001, selecao = 2'b10, entrada3 = 15'h1234; pc = 4.
- Stall:
  - Stimulus: hold avancar = 0 for 10 cycles in PRONTO.
  - Required: instrucao and valido stable, req_mem = 0; on avancar = 1, next req_mem appears 2 cycles later with endereco_mem = 4.
- Jump/branch decode:
  - Stimulus: dado_mem = 32'hF80F_FFFF, then dado_mem = 32'h8000_2001.
  - Required: first word gives selecao = 2'b00, entrada1 = 20'hFFFFF; second gives selecao = 2'b01, entrada2 = 14'h2001.
- Timeout:
  - Stimulus: with LIMITE_ESPERA = 4, never ack.
  - Required: req_mem high 4 cycles, low 1 cycle, then high again at the same address; erro_busca = 1 and stays set.
- Redirect collision:
  - Stimulus: in ESPERA, assert ack_mem and desvio simultaneously with endereco_desvio = 32'h100.
  - Required: valido stays 0, next fetch address is 32'h100, and the acked word is never presented.
- Wrap-around:
  - Stimulus: PC_INICIAL = 32'hFFFF_FFFC, then one fetch.
  - Required: pc_instrucao = 32'hFFFF_FFFC, next endereco_mem = 0.
